// File: rtl/uart_word_packer.sv
// -----------------------------------------------------------------------------
// uart_word_packer
//
// Purpose:
//   Sits behind the UART receiver. It collects BYTES_PER_WORD one-cycle byte
//   strobes into a little-endian word (first byte in bits [7:0]). Each finished
//   word is offered, together with its write address, to the RSA pipeline loader
//   over a valid/ready interface.
//   If a finished word arrives while the previous one is still unaccepted, the
//   new word is dropped and o_Overrun is set.
//   If a partial word sees no new byte for TIMEOUT_CLKS clocks, it is thrown
//   away and o_Timeout_Err is set.
//
// Optional feature:
//   UART_PACK_CKSUM_EN - when defined, adds o_Cksum. This is a running XOR of
//   every byte received since reset, including bytes of discarded or dropped
//   words.
//
// Ports:
//   i_Clock        system clock, rising edge
//   i_Rst_n        asynchronous active-low reset
//   i_Rx_DV        one-cycle strobe, i_Rx_Byte valid
//   i_Rx_Byte      received byte
//   o_Word_Valid   o_Word / o_Word_Addr hold a pending word
//   i_Word_Ready   consumer takes the word when o_Word_Valid & i_Word_Ready
//   o_Word         packed word (8*BYTES_PER_WORD bits)
//   o_Word_Addr    index of this word since reset
//   o_Overrun      sticky: a completed word was dropped
//   o_Timeout_Err  sticky: a partial word was discarded on timeout
//   o_Cksum        (UART_PACK_CKSUM_EN only) running XOR of all received bytes
//
// Handshake:
//   o_Word_Valid, o_Word and o_Word_Addr stay stable from the moment valid
//   rises until a clock edge sees valid & ready. On that edge the word is
//   accepted and the address counter advances. i_Word_Ready has no effect
//   while valid is low. The byte side cannot be back-pressured.
// -----------------------------------------------------------------------------
module uart_word_packer #(
   parameter int BYTES_PER_WORD = 4,
   parameter int ADDR_W         = 8,
   parameter int TIMEOUT_CLKS   = 2610
) (
   input  logic                        i_Clock,
   input  logic                        i_Rst_n,
   input  logic                        i_Rx_DV,
   input  logic [7:0]                  i_Rx_Byte,
   output logic                        o_Word_Valid,
   input  logic                        i_Word_Ready,
   output logic [8*BYTES_PER_WORD-1:0] o_Word,
   output logic [ADDR_W-1:0]           o_Word_Addr,
   output logic                        o_Overrun,
   output logic                        o_Timeout_Err
`ifdef UART_PACK_CKSUM_EN
   ,
   output logic [7:0]                  o_Cksum
`endif
);

   localparam int W     = 8 * BYTES_PER_WORD;
   localparam int IDX_W = $clog2(BYTES_PER_WORD);
   localparam int TMR_W = $clog2(TIMEOUT_CLKS) + 1;

   localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(BYTES_PER_WORD - 1);
   localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(TIMEOUT_CLKS - 1);

   typedef enum logic {
      S_IDLE    = 1'b0,
      S_COLLECT = 1'b1
   } state_t;

   state_t             state_q,      state_d;
   logic [IDX_W-1:0]   idx_q,        idx_d;
   logic [TMR_W-1:0]   timer_q,      timer_d;
   logic [W-1:0]       shreg_q,      shreg_d;
   logic [W-1:0]       word_q,       word_d;
   logic [ADDR_W-1:0]  word_addr_q,  word_addr_d;
   logic [ADDR_W-1:0]  addr_cnt_q,   addr_cnt_d;
   logic               valid_q,      valid_d;
   logic               overrun_q,    overrun_d;
   logic               timeout_q,    timeout_d;
   logic [7:0]         cksum_q,      cksum_d;

   logic               accept;
   logic               commit;
   logic [W-1:0]       word_next;

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      timer_d     = timer_q;
      shreg_d     = shreg_q;
      word_d      = word_q;
      word_addr_d = word_addr_q;
      addr_cnt_d  = addr_cnt_q;
      valid_d     = valid_q;
      overrun_d   = overrun_q;
      timeout_d   = timeout_q;
      cksum_d     = cksum_q;
      commit      = 1'b0;

      accept = valid_q & i_Word_Ready;

      // The incoming byte is placed at its final lane. This means the word
      // including the last byte is available in the strobe cycle itself, which
      // gives the 1-clock commit latency.
      word_next = shreg_q;
      word_next[{idx_q, 3'b000} +: 8] = i_Rx_Byte;

      if (i_Rx_DV) begin
         cksum_d = cksum_q ^ i_Rx_Byte;
      end

      case (state_q)
         S_IDLE: begin
            timer_d = '0;
            if (i_Rx_DV) begin
               shreg_d = word_next;
               idx_d   = IDX_W'(1);
               state_d = S_COLLECT;
            end
         end
         S_COLLECT: begin
            // A strobe always takes priority over the timeout check, so a
            // byte arriving in the expiry cycle is kept.
            if (i_Rx_DV) begin
               shreg_d = word_next;
               timer_d = '0;
               if (idx_q == IDX_LAST) begin
                  commit  = 1'b1;
                  idx_d   = '0;
                  state_d = S_IDLE;
               end else begin
                  idx_d = idx_q + IDX_W'(1);
               end
            end else if (timer_q == TMR_LAST) begin
               timer_d   = '0;
               idx_d     = '0;
               timeout_d = 1'b1;
               state_d   = S_IDLE;
            end else begin
               timer_d = timer_q + TMR_W'(1);
            end
         end
         default: begin
            state_d = S_IDLE;
            idx_d   = '0;
            timer_d = '0;
         end
      endcase

      if (accept) begin
         valid_d    = 1'b0;
         addr_cnt_d = addr_cnt_q + ADDR_W'(1);
      end

      // A word being accepted in this same cycle frees the output register.
      // The new word therefore takes the already-advanced address.
      if (commit) begin
         if (!valid_q || accept) begin
            word_d      = word_next;
            word_addr_d = addr_cnt_d;
            valid_d     = 1'b1;
         end else begin
            overrun_d = 1'b1;
         end
      end
   end

   always_ff @(posedge i_Clock or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         state_q     <= S_IDLE;
         idx_q       <= '0;
         timer_q     <= '0;
         shreg_q     <= '0;
         word_q      <= '0;
         word_addr_q <= '0;
         addr_cnt_q  <= '0;
         valid_q     <= 1'b0;
         overrun_q   <= 1'b0;
         timeout_q   <= 1'b0;
         cksum_q     <= '0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         timer_q     <= timer_d;
         shreg_q     <= shreg_d;
         word_q      <= word_d;
         word_addr_q <= word_addr_d;
         addr_cnt_q  <= addr_cnt_d;
         valid_q     <= valid_d;
         overrun_q   <= overrun_d;
         timeout_q   <= timeout_d;
         cksum_q     <= cksum_d;
      end
   end

   assign o_Word_Valid  = valid_q;
   assign o_Word        = word_q;
   assign o_Word_Addr   = word_addr_q;
   assign o_Overrun     = overrun_q;
   assign o_Timeout_Err = timeout_q;

`ifdef UART_PACK_CKSUM_EN
   assign o_Cksum = cksum_q;
`else
   // Without the checksum port, the XOR register has no consumer.
   logic cksum_unused;
   assign cksum_unused = ^cksum_q;
`endif

endmodule
